insert_coin: RTL and testbench

//   Coin-insertion stage (stage 3) of the ticket vending machine. Accepts coin

---
 rtl/insert_coin_pkg.sv | 25 ++
 rtl/insert_coin_decode.sv | 33 +++
 rtl/insert_coin.sv | 112 +++++++++++
 tb/tb_insert_coin.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/insert_coin_pkg.sv
// ----------------------------------------------------------------------------
// insert_coin_pkg
//   Shared definitions for the coin-insertion stage of the ticket vending
//   machine: FSM state encoding, coin-unit width and the legal coin codes.
// ----------------------------------------------------------------------------
package insert_coin_pkg;

    // Width of a coin code and of the credit register, in coin units.
    localparam int COIN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Coin codes. A legal code's numeric value is its worth in coin units.
    localparam logic [COIN_W-1:0] COIN_NONE = 8'h00;
    localparam logic [COIN_W-1:0] COIN_1    = 8'h01;
    localparam logic [COIN_W-1:0] COIN_2    = 8'h02;
    localparam logic [COIN_W-1:0] COIN_4    = 8'h04;
    localparam logic [COIN_W-1:0] COIN_8    = 8'h08;
    localparam logic [COIN_W-1:0] COIN_16   = 8'h10;

endpackage

// File: rtl/insert_coin_decode.sv
// ----------------------------------------------------------------------------
// insert_coin_decode
//   Classifies a raw coin code.
//   Ports:
//     coin_in  in   8  raw coin code
//     legal    out  1  coin_in is one of the legal codes
//     value    out  8  worth of the coin in coin units, 0 when not legal
// ----------------------------------------------------------------------------
module insert_coin_decode
    import insert_coin_pkg::*;
(
    input  logic [COIN_W-1:0] coin_in,
    output logic              legal,
    output logic [COIN_W-1:0] value
);

    // A case statement matches items exactly, so an X/Z bit in coin_in falls
    // through to the default arm and never produces credit.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        legal = 1'b0;
        value = COIN_NONE;
        case (coin_in)
            COIN_1, COIN_2, COIN_4, COIN_8, COIN_16: begin
                legal = 1'b1;
                value = coin_in;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/insert_coin.sv
// ----------------------------------------------------------------------------
// insert_coin
//   Coin-insertion stage of the ticket vending machine. Accumulates credit
//   from coin events and flags completion once credit reaches PRICE.
//   Parameters:
//     PRICE    credit needed to complete the stage, 1..255
//     TIMEOUT  idle cycles in ACCUM before credit is abandoned, >= 2
//   Ports:
//     clk         in   1  clock, all logic on posedge
//     rst         in   1  synchronous active-high reset
//     coin_in     in   8  coin code, 8'h00 = no coin
//     state_cmp3  out  1  stage complete, level, held until reset
//     out_RDY3    out  1  one-cycle strobe on the cycle after entering DONE
//     DATA_out3   out  8  accumulated credit in coin units
// ----------------------------------------------------------------------------
module insert_coin
    import insert_coin_pkg::*;
#(
    parameter int PRICE   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COIN_W-1:0] coin_in,
    output logic              state_cmp3,
    output logic              out_RDY3,
    output logic [COIN_W-1:0] DATA_out3
);

    localparam int                TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [COIN_W-1:0]  PRICE_C    = COIN_W'(PRICE);

    state_t              state,  state_nxt;
    logic [COIN_W-1:0]   credit, credit_nxt;
    logic [TIMER_W-1:0]  timer,  timer_nxt;
    logic [COIN_W-1:0]   coin_prev;

    logic                legal;
    logic [COIN_W-1:0]   value;
    logic                coin_event;
    logic [COIN_W:0]     sum;
    logic [COIN_W-1:0]   credit_sat;

    insert_coin_decode u_decode (
        .coin_in (coin_in),
        .legal   (legal),
        .value   (value)
    );

    // A coin counts only on its first cycle after a cycle with no legal coin,
    // so a held code counts once and a legal->legal change counts not at all.
    assign coin_event = legal && (coin_prev == COIN_NONE);

    // Extra carry bit detects overflow so credit saturates at all-ones.
    assign sum        = {1'b0, credit} + {1'b0, value};
    assign credit_sat = sum[COIN_W] ? {COIN_W{1'b1}} : sum[COIN_W-1:0];

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        timer_nxt  = timer;
        case (state)
            IDLE: begin
                if (coin_event) begin
                    credit_nxt = value;
                    timer_nxt  = '0;
                    state_nxt  = (value >= PRICE_C) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (coin_event) begin
                    credit_nxt = credit_sat;
                    timer_nxt  = '0;
                    if (credit_sat >= PRICE_C) state_nxt = DONE;
                end else if (timer == TIMER_LAST) begin
                    // Customer walked away: abandon the partial credit.
                    credit_nxt = '0;
                    timer_nxt  = '0;
                    state_nxt  = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            DONE: ;  // coins ignored, left only through reset
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            credit     <= '0;
            timer      <= '0;
            coin_prev  <= '0;
            state_cmp3 <= 1'b0;
            out_RDY3   <= 1'b0;
        end else begin
            state      <= state_nxt;
            credit     <= credit_nxt;
            timer      <= timer_nxt;
            coin_prev  <= value;  // illegal codes are stored as no coin
            state_cmp3 <= (state_nxt == DONE);
            out_RDY3   <= (state_nxt == DONE) && (state != DONE);
        end
    end

    assign DATA_out3 = credit;

endmodule

// File: tb/tb_insert_coin.sv
// ----------------------------------------------------------------------------
// tb_insert_coin
//   Self-checking bench for insert_coin. Two instances share the stimulus:
//   dut0 uses the default PRICE/TIMEOUT, dut1 uses a high price and the
//   shortest timeout so credit saturation and the minimum timeout are hit.
//   The reference model tracks credit as a plain integer and decides
//   completion/abandonment from the stage rules directly.
// ----------------------------------------------------------------------------
module tb_insert_coin;

    localparam int N = 2;
    localparam int PRICE0 = 5,   TMO0 = 16;
    localparam int PRICE1 = 250, TMO1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] coin_in;
    logic       cmp0, rdy0, cmp1, rdy1;
    logic [7:0] data0, data1;

    always #5 clk = ~clk;

    insert_coin #(.PRICE(PRICE0), .TIMEOUT(TMO0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .coin_in    (coin_in),
        .state_cmp3 (cmp0),
        .out_RDY3   (rdy0),
        .DATA_out3  (data0)
    );

    insert_coin #(.PRICE(PRICE1), .TIMEOUT(TMO1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .coin_in    (coin_in),
        .state_cmp3 (cmp1),
        .out_RDY3   (rdy1),
        .DATA_out3  (data1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int price [N] = '{PRICE0, PRICE1};
    int tmo   [N] = '{TMO0, TMO1};
    int m_credit [N];
    int m_idle   [N];
    bit m_done   [N];
    bit m_rdy    [N];
    int m_prev;

    function automatic bit is_legal(input logic [7:0] c);
        return (c == 8'h01) || (c == 8'h02) || (c == 8'h04) ||
               (c == 8'h08) || (c == 8'h10);
    endfunction

    function automatic void model_edge(input logic [7:0] c, input logic r);
        int v;
        bit ev;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_credit[i] = 0; m_idle[i] = 0; m_done[i] = 0; m_rdy[i] = 0;
            end
            m_prev = 0;
            return;
        end
        v  = is_legal(c) ? int'(c) : 0;
        ev = (v != 0) && (m_prev == 0);
        for (int i = 0; i < N; i++) begin
            m_rdy[i] = 0;
            if (m_done[i]) continue;
            if (ev) begin
                m_credit[i] = (m_credit[i] + v > 255) ? 255 : m_credit[i] + v;
                m_idle[i]   = 0;
                if (m_credit[i] >= price[i]) begin
                    m_done[i] = 1;
                    m_rdy[i]  = 1;
                end
            end else if (m_credit[i] > 0) begin
                // Collecting credit: count idle cycles toward abandonment.
                m_idle[i]++;
                if (m_idle[i] == tmo[i]) begin
                    m_credit[i] = 0;
                    m_idle[i]   = 0;
                end
            end
        end
        m_prev = v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare all outputs.
    task automatic tick(input logic [7:0] c, input logic r, input string tag);
        coin_in = c;
        rst     = r;
        @(posedge clk);
        model_edge(c, r);
        #1;
        check({tag, ".data0"}, data0, 8'(m_credit[0]));
        check({tag, ".cmp0"},  {7'd0, cmp0}, {7'd0, m_done[0]});
        check({tag, ".rdy0"},  {7'd0, rdy0}, {7'd0, m_rdy[0]});
        check({tag, ".data1"}, data1, 8'(m_credit[1]));
        check({tag, ".cmp1"},  {7'd0, cmp1}, {7'd0, m_done[1]});
        check({tag, ".rdy1"},  {7'd0, rdy1}, {7'd0, m_rdy[1]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        logic       r;
        logic [7:0] last_c;

        rst     = 1'b1;
        coin_in = 8'h00;

        // Reset state
        tick(8'h00, 1'b1, "t1_reset");

        // Single 1-unit coin, then idle: credit 1, not complete
        tick(8'h01, 1'b0, "t2_coin");
        repeat (5) tick(8'h00, 1'b0, "t2_idle");

        // 4-unit coin completes the price of 5; outputs hold afterwards
        tick(8'h04, 1'b0, "t3_coin");
        repeat (6) tick(8'h00, 1'b0, "t3_hold");

        // Held code counts once; illegal code adds nothing
        tick(8'h00, 1'b1, "t4_rst");
        repeat (4) tick(8'h02, 1'b0, "t4_held");
        tick(8'h00, 1'b0, "t4_gap");
        tick(8'h03, 1'b0, "t4_illegal");
        tick(8'h00, 1'b0, "t4_gap2");
        // Direct legal->legal change is not a new coin
        tick(8'h01, 1'b0, "t4_l1");
        tick(8'h02, 1'b0, "t4_l2");
        tick(8'h00, 1'b0, "t4_gap3");

        // Timeout abandons credit after TIMEOUT idle cycles
        tick(8'h00, 1'b1, "t5_rst");
        tick(8'h01, 1'b0, "t5_coin");
        repeat (TMO0) tick(8'h00, 1'b0, "t5_idle");
        tick(8'h00, 1'b0, "t5_after");

        // Overpayment kept; coins ignored in DONE; reset clears with no strobe
        tick(8'h00, 1'b1, "t6_rst");
        tick(8'h04, 1'b0, "t6_c1");
        tick(8'h00, 1'b0, "t6_gap");
        tick(8'h04, 1'b0, "t6_c2");
        tick(8'h00, 1'b0, "t6_gap2");
        tick(8'h02, 1'b0, "t6_ignored");
        tick(8'h00, 1'b0, "t6_gap3");
        tick(8'h00, 1'b1, "t6_rst2");
        tick(8'h00, 1'b0, "t6_post");

        // Saturation at 255 on the high-price instance
        repeat (16) begin
            tick(8'h10, 1'b0, "t7_coin");
            tick(8'h00, 1'b0, "t7_gap");
        end
        tick(8'h00, 1'b0, "t7_after");

        // Randomized traffic
        tick(8'h00, 1'b1, "rnd_rst");
        last_c = 8'h00;
        for (int k = 0; k < 800; k++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      c = 8'h00;
            else if (sel < 75) c = 8'h01 << $urandom_range(0, 4);
            else if (sel < 90) c = last_c;
            else               c = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 59) == 0);
            tick(c, r, "rnd");
            last_c = c;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
